gpu_fetch_stage: RTL and testbench
==================================

// Module: gpu_fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the PC, issues
//  one-outstanding requests to instruction memory over a req/ready + rvalid handshake, and drives
//  if_inst/if_pc into IF/ID. Handles hazard stall (skid-buffers a response), branch redirect
//  (kills in-flight fetch) and HALT opcode detection. Bubble = NOP_INST (all-zero, matches IF/ID flush).
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  HALT_OP    6'h3F          opcode (inst[31:26]) that stops fetching after delivery
//  NOP_INST   32'h0000_0000  bubble word driven on if_inst
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   reset, asynchronous, active-high
//  start        in   1   leave IDLE and begin fetching at current PC
//  stall        in   1   downstream stall (same signal as IF/ID stall); if_* must hold
//  redirect     in   1   branch/jump taken; overrides everything except rst
//  redirect_pc  in   32  redirect target; bits [1:0] forced to 0
//  imem_req     out  1   request valid
//  imem_addr    out  32  request address (= pc)
//  imem_ready   in   1   request accepted this cycle when imem_req && imem_ready
//  imem_rvalid  in   1   response valid (exactly one per accepted request, >=1 cycle later)
//  imem_rdata   in   32  response instruction
//  if_inst      out  32  instruction to IF/ID (NOP_INST when no valid instruction)
//  if_pc        out  32  PC of if_inst
//  halted       out  1   HALT_OP delivered; fetching stopped
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, if_inst=NOP_INST, if_pc=0, halted=0, drop=0,
//   buf_valid=0. imem_req combinational: 1 only in FETCH. imem_addr=pc always.
//  States: IDLE, FETCH, WAIT, HOLD, HALT.
//   IDLE : start -> FETCH. redirect in IDLE loads pc only.
//   FETCH: imem_req=1. imem_ready -> WAIT. stall does not block issue.
//   WAIT : on imem_rvalid (drop=0): if !stall -> if_inst<=rdata, if_pc<=pc, pc<=pc+4, -> FETCH
//          (or HALT if rdata[31:26]==HALT_OP); if stall -> buf<=rdata, -> HOLD.
//   HOLD : when !stall deliver buf exactly as WAIT delivery (incl. HALT check), -> FETCH/HALT.
//   HALT : imem_req=0, halted=1; left only by redirect (-> FETCH, halted<=0) or rst.
//  Output update: if_* registered; response at cycle N with !stall appears on if_inst at N+1.
//   stall=1: if_inst/if_pc hold. stall=0 and nothing delivered: if_inst<=NOP_INST, if_pc holds.
//  pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  Redirect (stall-independent, highest priority after rst):
//   pc<=redirect_pc&~3; if_inst<=NOP_INST; buf_valid<=0; halted<=0.
//   FETCH & imem_ready same cycle -> WAIT with drop=1 (old-PC response discarded).
//   FETCH w/o ready, HOLD, HALT -> FETCH. WAIT w/o rvalid -> WAIT, drop=1.
//   WAIT & rvalid same cycle -> response discarded, -> FETCH.
//  drop=1 in WAIT: next rvalid discarded, drop<=0, -> FETCH; no delivery, pc unchanged.
//  At most one outstanding request; imem_req never asserted in WAIT/HOLD.
//  rst mid-transaction: state cleared immediately; a late rvalid in IDLE is ignored.
// TESTING
//  1 rst, start, 1-cycle memory, stall=0 -> addrs 0,4,8,...; if_inst = mem words, 1 per 2 cycles.
//  2 stall=1 for 3 cycles while rvalid of PC 8 -> HOLD; if_inst/if_pc frozen; PC 8 word
//    delivered the cycle after stall drops, next request addr 12, no word lost or duplicated.
//  3 redirect to 32'h103 while WAIT (latency 4) -> in-flight word dropped, if_inst=0,
//    next imem_addr=32'h100, first delivered if_pc=32'h100.
//  4 word with opcode 6'h3F at PC 0x10 -> delivered, halted=1, imem_req stays 0 for 20 cycles;
//    redirect to 0x40 -> halted=0, fetch resumes at 0x40.
//  5 RESET_PC=32'hFFFF_FFFC -> second fetch addr 0; rst asserted in WAIT -> outputs reset
//    asynchronously, stale rvalid ignored, IDLE until start.

Source files
------------

// File: rtl/gpu_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register.
// Keeps one request outstanding to instruction memory, parks a response in a
// one-entry skid buffer while the pipe is stalled, discards the in-flight
// response on a branch redirect and stops fetching after delivering a HALT.
//
// Handshake: a request moves when imem_req && imem_ready are both high on a
// rising clk edge. Exactly one imem_rvalid pulse answers each accepted request,
// at least one cycle later. imem_req is only ever high in FETCH.
module gpu_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'h3F,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        halted
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]  state;
    logic [31:0] pc;
    logic        drop;
    logic        buf_valid;
    logic [31:0] buf_data;

    logic        deliver_en;
    logic [31:0] deliver_data;
    logic        deliver_halt;

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;

    // Pick the word handed to IF/ID this cycle: a fresh response or the skid buffer.
    always_comb begin
        deliver_en   = 1'b0;
        deliver_data = buf_data;
        if (!redirect && !stall) begin
            if (state == S_WAIT && imem_rvalid && !drop) begin
                deliver_en   = 1'b1;
                deliver_data = imem_rdata;
            end else if (state == S_HOLD && buf_valid) begin
                deliver_en   = 1'b1;
                deliver_data = buf_data;
            end
        end
        deliver_halt = (deliver_data[31:26] == HALT_OP);
    end

    // Fetch FSM, PC, skid buffer and registered IF/ID outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            if_inst   <= NOP_INST;
            if_pc     <= 32'h0;
            halted    <= 1'b0;
            drop      <= 1'b0;
            buf_valid <= 1'b0;
            buf_data  <= 32'h0;
        end else if (redirect) begin
            // Redirect wins over stall; any word still owed by memory is marked for discard.
            pc        <= redirect_pc & ~32'h3;
            if_inst   <= NOP_INST;
            buf_valid <= 1'b0;
            halted    <= 1'b0;
            case (state)
                S_IDLE: state <= S_IDLE;
                S_FETCH: begin
                    if (imem_ready) begin
                        state <= S_WAIT;
                        drop  <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= S_FETCH;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end else if (deliver_en) begin
            if_inst   <= deliver_data;
            if_pc     <= pc;
            pc        <= pc + 32'd4;
            buf_valid <= 1'b0;
            if (deliver_halt) begin
                state  <= S_HALT;
                halted <= 1'b1;
            end else begin
                state  <= S_FETCH;
            end
        end else begin
            // Nothing delivered: bubble unless the downstream register is holding.
            if (!stall) begin
                if_inst <= NOP_INST;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_FETCH;
                        end else begin
                            // Only reachable with stall high: park the word.
                            buf_data  <= imem_rdata;
                            buf_valid <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_fetch_stage.sv
// Directed bench for gpu_fetch_stage: a responding memory model drives the
// main instance; a second instance with a wrapping reset PC is driven by hand.
module tb_gpu_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        halted;

    logic        rst2 = 1'b1;
    logic        start2 = 1'b0;
    logic        stall2 = 1'b0;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        req2;
    logic [31:0] addr2;
    logic        ready2 = 1'b1;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic [31:0] if_inst2;
    logic [31:0] if_pc2;
    logic        halted2;

    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] raddr = 32'h0;
    logic [31:0] halt_addr = 32'h1;

    always #5 clk = ~clk;

    gpu_fetch_stage dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_inst(if_inst), .if_pc(if_pc), .halted(halted)
    );

    gpu_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst2), .start(start2), .stall(stall2),
        .redirect(redirect2), .redirect_pc(redirect_pc2),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .if_inst(if_inst2), .if_pc(if_pc2), .halted(halted2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == halt_addr) return {6'h3F, a[25:0]};
        return {6'h28, a[25:0]};
    endfunction

    // Memory model: answers each accepted request after lat cycles, ignores rst.
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(raddr);
            end
        end
        if (imem_req && imem_ready) begin
            raddr <= imem_addr;
            if (lat == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(imem_addr);
            end else begin
                cnt <= lat - 1;
            end
        end
    end

    task automatic do_reset_start();
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h expected 0", if_inst); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        int          nreq;
        int          ndel;
        lat = 1;
        do_reset_start();
        exp_addr = 32'h0; exp_pc = 32'h0; nreq = 0; ndel = 0;
        for (int i = 0; i < 12; i++) begin
            if (imem_req) begin
                checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL stream_addr: got %h expected %h", imem_addr, exp_addr); end
                exp_addr += 32'd4; nreq++;
            end
            if (if_inst !== 32'h0) begin
                checks++; if (if_inst !== mem_word(exp_pc) || if_pc !== exp_pc) begin failures++; $display("FAIL stream_word: got %h@%h expected %h@%h", if_inst, if_pc, mem_word(exp_pc), exp_pc); end
                exp_pc += 32'd4; ndel++;
            end
            @(negedge clk);
        end
        checks++; if (nreq !== 6) begin failures++; $display("FAIL stream_nreq: got %0d expected 6", nreq); end
        checks++; if (ndel !== 5) begin failures++; $display("FAIL stream_ndel: got %0d expected 5", ndel); end
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset_start();
        repeat (4) @(negedge clk);
        checks++; if (if_inst !== mem_word(32'h4) || if_pc !== 32'h4) begin failures++; $display("FAIL stall_pre: got %h@%h expected %h@4", if_inst, if_pc, mem_word(32'h4)); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (if_inst !== mem_word(32'h4) || if_pc !== 32'h4 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_hold%0d: got %h@%h req=%b expected %h@4 req=0", i, if_inst, if_pc, imem_req, mem_word(32'h4)); end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (if_inst !== mem_word(32'h8) || if_pc !== 32'h8) begin failures++; $display("FAIL stall_release: got %h@%h expected %h@8", if_inst, if_pc, mem_word(32'h8)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL stall_next_req: got req=%b addr=%h expected req=1 addr=c", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL stall_bubble: got %h expected 0", if_inst); end
        @(negedge clk);
        checks++; if (if_inst !== mem_word(32'hC) || if_pc !== 32'hC) begin failures++; $display("FAIL stall_after: got %h@%h expected %h@c", if_inst, if_pc, mem_word(32'hC)); end
    endtask

    task automatic test_redirect();
        lat = 4;
        do_reset_start();
        repeat (2) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b0 || if_inst !== 32'h0) begin failures++; $display("FAIL redir_wait: got addr=%h req=%b inst=%h expected addr=100 req=0 inst=0", imem_addr, imem_req, if_inst); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_still_wait: got %b expected 0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_inst !== 32'h0) begin failures++; $display("FAIL redir_refetch: got req=%b addr=%h inst=%h expected req=1 addr=100 inst=0", imem_req, imem_addr, if_inst); end
        for (int i = 0; i < 12 && if_inst === 32'h0; i++) @(negedge clk);
        checks++; if (if_inst !== mem_word(32'h100) || if_pc !== 32'h100) begin failures++; $display("FAIL redir_first: got %h@%h expected %h@100", if_inst, if_pc, mem_word(32'h100)); end
    endtask

    task automatic test_halt();
        int bad;
        lat = 1;
        halt_addr = 32'h10;
        do_reset_start();
        for (int i = 0; i < 30 && halted !== 1'b1; i++) @(negedge clk);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_seen: got %b expected 1", halted); end
        checks++; if (if_inst !== {6'h3F, 26'h10} || if_pc !== 32'h10) begin failures++; $display("FAIL halt_word: got %h@%h expected fc000010@10", if_inst, if_pc); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL halt_quiet: got %0d bad cycles expected 0", bad); end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h expected 0 1 40", halted, imem_req, imem_addr); end
        for (int i = 0; i < 10 && if_inst === 32'h0; i++) @(negedge clk);
        checks++; if (if_inst !== mem_word(32'h40) || if_pc !== 32'h40) begin failures++; $display("FAIL halt_first: got %h@%h expected %h@40", if_inst, if_pc, mem_word(32'h40)); end
        halt_addr = 32'h1;
    endtask

    task automatic test_wrap_and_reset();
        int bad;
        @(negedge clk);
        rst2 = 1'b0;
        checks++; if (req2 !== 1'b0 || addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_idle: got req=%b addr=%h expected 0 fffffffc", req2, addr2); end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req0: got req=%b addr=%h expected 1 fffffffc", req2, addr2); end
        @(negedge clk);
        rvalid2 = 1'b1;
        rdata2 = 32'h1234_5678;
        @(negedge clk);
        rvalid2 = 1'b0;
        checks++; if (if_inst2 !== 32'h1234_5678 || if_pc2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_deliver: got %h@%h expected 12345678@fffffffc", if_inst2, if_pc2); end
        checks++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin failures++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1 0", req2, addr2); end
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        checks++; if (if_inst2 !== 32'h0 || if_pc2 !== 32'h0 || addr2 !== 32'hFFFF_FFFC || req2 !== 1'b0) begin failures++; $display("FAIL async_rst: got inst=%h pc=%h addr=%h req=%b expected 0 0 fffffffc 0", if_inst2, if_pc2, addr2, req2); end
        @(negedge clk);
        rst2 = 1'b0;
        rvalid2 = 1'b1;
        rdata2 = 32'h0BAD_0001;
        @(negedge clk);
        rvalid2 = 1'b0;
        bad = 0;
        repeat (4) begin
            if (if_inst2 !== 32'h0 || req2 !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stale_rvalid: got %0d bad cycles expected 0", bad); end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL restart: got req=%b addr=%h expected 1 fffffffc", req2, addr2); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
